// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 slave serving a bank of 8-bit alarm registers.
// Define SPI_REG_BURST_EN to keep streaming data bytes to consecutive addresses within one CS frame.
module spi_reg_responder #(
  parameter int          NUM_REGS    = 8,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  CS,
  output logic                  MISO,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  wr_pulse,
  output logic [6:0]            wr_addr,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DRAIN} state_t;

  state_t      state, next_state;
  logic [1:0]  sclk_sync, mosi_sync, cs_sync;
  logic        sclk_prev, cs_prev;
  logic [7:0]  mem [NUM_REGS];
  logic [7:0]  rx_shift, tx_shift, tx_load;
  logic [2:0]  bit_cnt;
  logic        load_pending;
  logic        is_write;
  logic [6:0]  addr;

  logic        sclk_now, mosi_now, cs_now;
  logic        sclk_rise, sclk_fall, cs_fall;
  logic        byte_done, in_range;
  logic [7:0]  rx_byte;

  function automatic logic [7:0] read_reg(input logic [6:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == 7'(i)) r = mem[i];
    return r;
  endfunction

  assign sclk_now  = sclk_sync[1];
  assign mosi_now  = mosi_sync[1];
  assign cs_now    = cs_sync[1];
  assign sclk_rise = sclk_now & ~sclk_prev;
  assign sclk_fall = ~sclk_now & sclk_prev;
  // Synchronizer and history reset low so a CS already held low after reset is not seen as a new frame.
  assign cs_fall   = cs_prev & ~cs_now;
  assign rx_byte   = {rx_shift[6:0], mosi_now};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign in_range  = (32'(addr) < NUM_REGS);

  assign busy = (state != IDLE);
  assign MISO = (state == CMD || state == DATA) ? tx_shift[7] : 1'b0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[8*g +: 8] = mem[g];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b00;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], SCLK};
      mosi_sync <= {mosi_sync[0], MOSI};
      cs_sync   <= {cs_sync[0], CS};
      sclk_prev <= sclk_now;
      cs_prev   <= cs_now;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (cs_fall) next_state = CMD;
      CMD: begin
        if (cs_now)         next_state = IDLE;
        else if (byte_done) next_state = DATA;
      end
      DATA: begin
        if (cs_now) next_state = IDLE;
`ifdef SPI_REG_BURST_EN
        else if (byte_done) next_state = DATA;
`else
        else if (byte_done) next_state = DRAIN;
`endif
      end
      DRAIN: if (cs_now) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
      rx_shift     <= 8'h00;
      tx_shift     <= 8'h00;
      tx_load      <= 8'h00;
      bit_cnt      <= 3'd0;
      load_pending <= 1'b0;
      is_write     <= 1'b0;
      addr         <= 7'd0;
      wr_pulse     <= 1'b0;
      wr_addr      <= 7'd0;
    end else begin
      wr_pulse <= 1'b0;
      // A deasserted CS overrides any coincident SCLK edge, so partial bytes never commit.
      if (cs_now) begin
        bit_cnt      <= 3'd0;
        load_pending <= 1'b0;
        tx_shift     <= 8'h00;
      end else if (state == IDLE) begin
        if (cs_fall) begin
          tx_shift <= STATUS_BYTE;
          bit_cnt  <= 3'd0;
        end
      end else if (state == CMD || state == DATA) begin
        if (sclk_rise) begin
          rx_shift <= rx_byte;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state == CMD) begin
              is_write     <= rx_byte[7];
              addr         <= rx_byte[6:0];
              tx_load      <= rx_byte[7] ? 8'h00 : read_reg(rx_byte[6:0]);
              load_pending <= 1'b1;
            end else begin
              if (is_write && in_range) begin
                for (int i = 0; i < NUM_REGS; i++)
                  if (addr == 7'(i)) mem[i] <= rx_byte;
                wr_pulse <= 1'b1;
                wr_addr  <= addr;
              end
`ifdef SPI_REG_BURST_EN
              addr         <= addr + 7'd1;
              tx_load      <= is_write ? 8'h00 : read_reg(addr + 7'd1);
              load_pending <= 1'b1;
`endif
            end
          end
        end else if (sclk_fall) begin
          // The byte chosen at the 8th rise goes out starting at the following fall.
          if (load_pending) begin
            tx_shift     <= tx_load;
            load_pending <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 slave that sits behind the alarm-system SPI bus and serves a small bank of 8-bit alarm configuration/status registers to an SPI master.
- Oversamples SCLK/MOSI/CS with the system Clock and decodes a command byte (R/W + address), then a data byte.
- Drives MISO back to the master and exposes the register bank plus a write strobe to the alarm logic.

Parameters:
- NUM_REGS, 8, number of 8-bit registers; legal 1..128.
- STATUS_BYTE, 8'hA5, byte shifted out on MISO during the command byte.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- Clock  input  1  system clock; all logic on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- SCLK  input  1  SPI clock from master, asynchronous to Clock.
- MOSI  input  1  master-out data, asynchronous.
- CS  input  1  active-low chip select, asynchronous.
- MISO  output  1  slave-out data.
- regs  output  NUM_REGS*8  flattened register bank; reg i is regs[8*i+7:8*i].
- wr_pulse  output  1  one-Clock pulse when a register is written.
- wr_addr  output  7  address of the last write; valid with wr_pulse.
- busy  output  1  high while a transaction is in progress (synchronized CS low).

Behaviour:
- Synchronization:
  - SCLK, MOSI and CS each pass through a 2-flop synchronizer.
  - Edges are detected on synchronized SCLK (rise = prev 0, now 1).
  - Requirement on the master: SCLK high and low phases are each >= 4 Clock cycles.
- Reset (async, all outputs):
  - MISO=0, wr_pulse=0, wr_addr=0, busy=0, every reg=RESET_VAL.
  - State returns to IDLE; bit counter = 0.
- Bit order: MSB first in both directions. MOSI is sampled on SCLK rise; MISO is updated on SCLK fall.
- FSM states: IDLE, CMD, DATA, DRAIN.
- IDLE:
  - MISO=0.
  - Synchronized CS falling -> CMD; load TX shifter with STATUS_BYTE; MISO = STATUS_BYTE[7] immediately; busy=1.
- CMD:
  - Shift in 8 bits.
  - On the 8th rise, latch cmd: bit7 = 1 write / 0 read; bits[6:0] = addr.
  - For a read, load the TX shifter with regs[addr], or 8'h00 if addr >= NUM_REGS.
  - Go to DATA. The first DATA bit appears on MISO on the next SCLK fall.
- DATA:
  - Shift in 8 bits; on reads, shift out the loaded byte.
  - On the 8th rise of a write:
    - If addr < NUM_REGS: regs[addr] <= rx byte on the next Clock; wr_pulse=1 for exactly that cycle; wr_addr=addr.
    - If addr >= NUM_REGS: write dropped, no pulse.
  - Reads never pulse wr_pulse.
  - After the 8th rise, go to DRAIN (or stay in DATA with burst, see Optional Feature).
- DRAIN: further SCLK edges are ignored and MISO=0 until CS rises.
- CS rise in any state:
  - Go to IDLE within 3 Clocks of the raw CS edge; busy=0; MISO=0.
  - Partial bytes are discarded; no write occurs for an incomplete data byte.
- Simultaneous events:
  - CS rise and an SCLK rise in the same synchronized cycle: the CS rise wins and the edge is ignored.
  - A write completing in the same cycle as CS rise still commits only if all 8 bits were already sampled.
- Reset mid-transaction: immediate abort, all state as at reset; the master must re-assert CS to start over.
- Same-transaction readback: a read issued right after a write in a new CS frame returns the new value.

Optional Feature:
- Macro: SPI_REG_BURST_EN.
- Defined:
  - After each completed DATA byte, addr increments by 1 modulo 128 and the FSM stays in DATA.
  - Reads reload the TX shifter from the new addr; writes commit each byte with its own wr_pulse.
  - Out-of-range addresses follow the drop / 8'h00 rules.
- Undefined: exactly one data byte per CS frame, then DRAIN.

Test Plan:
- Reset asserted mid-way through a write -> regs all 8'h00, MISO=0, busy=0, no wr_pulse; the next full write frame works normally.
- Write cmd 8'h83 then data 8'h5A -> regs[3]=8'h5A; one wr_pulse with wr_addr=3; MISO during the cmd byte = 8'hA5.
- Read cmd 8'h03 after the above -> master receives 8'h5A in the data byte; no wr_pulse.
- Write cmd 8'hFF (addr 127 >= NUM_REGS) data 8'h11 -> no reg change, no pulse; read cmd 8'h7F returns 8'h00.
- CS deasserted after 5 bits of the data byte of write 8'h82/8'hC3 -> regs[2] unchanged, FSM back to IDLE, busy=0.
- With SPI_REG_BURST_EN: cmd 8'h86, data 8'h01, 8'h02, 8'h03 -> regs[6]=8'h01, regs[7]=8'h02, addr 8 dropped; two wr_pulses. Without the macro: only regs[6] is written, the rest are ignored.
